l2_cmd_responder: RTL and testbench

// Next-level (L2) end of the L1 data cache command interface. Samples the 26-bit line address and 2-bit command
// the L1 issues each clock, queues legal requests in a FIFO, and services them one at a time with a fixed per-command latency.

---
 rtl/l2_cmd_responder_if.sv | 35 +++
 rtl/l2_cmd_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_l2_cmd_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cmd_responder_if.sv
// L1 <-> L2 command interface: request sampling inputs, completion pulse and statistics outputs.
// Latency: none, wires only.
// Backpressure: none; the L1 side never stalls.
interface l2_cmd_responder_if #(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
);
    logic [1:0]                    cmd_in;
    logic [ADDR_W-1:0]             add_in;
    logic                          stats_clr;
    logic                          resp_valid;
    logic [1:0]                    resp_cmd;
    logic [ADDR_W-1:0]             resp_addr;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [CNT_W-1:0]              rd_count;
    logic [CNT_W-1:0]              wr_count;
    logic [CNT_W-1:0]              drop_count;
    logic [CNT_W-1:0]              illegal_count;

    // L1 / stimulus side
    modport master (
        output cmd_in, add_in, stats_clr,
        input  resp_valid, resp_cmd, resp_addr, busy, fifo_count,
               rd_count, wr_count, drop_count, illegal_count
    );

    // L2 responder side
    modport slave (
        input  cmd_in, add_in, stats_clr,
        output resp_valid, resp_cmd, resp_addr, busy, fifo_count,
               rd_count, wr_count, drop_count, illegal_count
    );
endinterface

// File: rtl/l2_cmd_responder.sv
// Generic synchronous FIFO with occupancy count; a push into a full FIFO is accepted on a popping edge.
// Latency: entry visible at pop_dat the edge after push (no bypass); count reflects post-edge occupancy.
// Backpressure: push_rdy low only when full and not popping on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_vld,
    input  logic [WIDTH-1:0]          push_dat,
    output logic                      push_rdy,
    output logic                      pop_vld,
    input  logic                      pop_rdy,
    output logic [WIDTH-1:0]          pop_dat,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_vld  = (count_q != '0);
    assign pop_ok   = pop_vld && pop_rdy;
    assign push_rdy = (count_q != FULL_CNT) || pop_ok;
    assign push_ok  = push_vld && push_rdy;
    assign pop_dat  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next storage, pointers and occupancy from the accepted push/pop pair
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// L2 responder: queues L1 READ/WRITE requests and completes them one at a time with a fixed per-command latency.
// Latency: request into idle block at edge T -> resp_valid in the cycle after edge T+LAT+1; LAT+2 cycles per request.
// Backpressure: none toward L1; requests arriving at a full FIFO (without a same-edge pop) are dropped and counted.
module l2_cmd_responder #(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 8,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_cmd_responder_if.slave l1
);
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;
    localparam int REQ_W   = 2 + ADDR_W;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] RD_LAT_M1 = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0] WR_LAT_M1 = LAT_W'(WRITE_LAT - 1);

    typedef struct packed {
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cur_cmd_q, cur_cmd_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    ill_cnt_q, ill_cnt_d;

    req_t                        push_dat;
    req_t                        pop_dat;
    logic                        push_vld;
    logic                        push_rdy;
    logic                        pop_vld;
    logic                        pop_rdy;
    logic                        enter_resp;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    assign push_vld = (l1.cmd_in == CMD_RD) || (l1.cmd_in == CMD_WR);
    assign push_dat = '{cmd: l1.cmd_in, addr: l1.add_in};

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (pop_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (pop_dat),
        .count    (fifo_cnt)
    );

    // Service FSM: pop in IDLE, count down the command latency in BUSY, pulse the completion in RESP
    always_comb begin
        state_d    = state_q;
        cur_cmd_d  = cur_cmd_q;
        cur_addr_d = cur_addr_q;
        lat_cnt_d  = lat_cnt_q;
        pop_rdy    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop_rdy = 1'b1;
                if (pop_vld) begin
                    cur_cmd_d  = pop_dat.cmd;
                    cur_addr_d = pop_dat.addr;
                    lat_cnt_d  = (pop_dat.cmd == CMD_RD) ? RD_LAT_M1 : WR_LAT_M1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Statistics: completions counted on the edge entering RESP; a same-edge clear takes priority
    always_comb begin
        rd_cnt_d   = rd_cnt_q   + CNT_W'(enter_resp && (cur_cmd_q == CMD_RD));
        wr_cnt_d   = wr_cnt_q   + CNT_W'(enter_resp && (cur_cmd_q == CMD_WR));
        drop_cnt_d = drop_cnt_q + CNT_W'(push_vld && !push_rdy);
        ill_cnt_d  = ill_cnt_q  + CNT_W'(l1.cmd_in == CMD_ILL);
        if (l1.stats_clr) begin
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            drop_cnt_d = '0;
            ill_cnt_d  = '0;
        end
    end

    // FSM, in-service request and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_cmd_q  <= '0;
            cur_addr_q <= '0;
            lat_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
            ill_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_cmd_q  <= cur_cmd_d;
            cur_addr_q <= cur_addr_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign l1.resp_valid    = (state_q == ST_RESP);
    assign l1.resp_cmd      = (state_q == ST_RESP) ? cur_cmd_q  : '0;
    assign l1.resp_addr     = (state_q == ST_RESP) ? cur_addr_q : '0;
    assign l1.busy          = (state_q != ST_IDLE) || (fifo_cnt != '0);
    assign l1.fifo_count    = fifo_cnt;
    assign l1.rd_count      = rd_cnt_q;
    assign l1.wr_count      = wr_cnt_q;
    assign l1.drop_count    = drop_cnt_q;
    assign l1.illegal_count = ill_cnt_q;
endmodule

// File: tb/tb_l2_cmd_responder.sv
// Testbench for l2_cmd_responder: randomized L1 command stream against a timestamp-based service model.
// Latency: checks every output each cycle on the falling edge.
// Backpressure: none; dropped requests are predicted from queue occupancy.
module tb_l2_cmd_responder;
    localparam int ADDR_W = 26;
    localparam int DEPTH  = 8;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;
    localparam int CNT_W  = 32;

    logic clk;
    logic rst_n;

    l2_cmd_responder_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) ifc ();

    l2_cmd_responder #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .READ_LAT   (RD_LAT),
        .WRITE_LAT  (WR_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .l1    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } req_s;

    // Reference model: queue contents plus the edge at which the server may next take a request
    req_s        mq[$];
    req_s        sb[$];
    int          edge_no;
    int          next_pop_edge;
    int          comp_edge;
    logic [1:0]  comp_cmd;
    bit          exp_resp;
    bit          exp_busy;
    logic [31:0] m_rd, m_wr, m_drop, m_ill;
    bit          started;

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        next_pop_edge = 0;
        comp_edge     = -1;
        comp_cmd      = 2'b00;
        exp_resp      = 1'b0;
        exp_busy      = 1'b0;
        m_rd = '0; m_wr = '0; m_drop = '0; m_ill = '0;
    endtask

    // Advance the model by one clock edge given the inputs presented at that edge
    task automatic model_edge(input logic [1:0] c, input logic [ADDR_W-1:0] a, input bit clr);
        req_s r;
        int   lat;
        exp_resp = (edge_no == comp_edge);
        if (exp_resp) begin
            if (comp_cmd == 2'b01) m_rd++;
            else                   m_wr++;
        end
        if (edge_no >= next_pop_edge && mq.size() > 0) begin
            r             = mq.pop_front();
            lat           = (r.cmd == 2'b01) ? RD_LAT : WR_LAT;
            comp_edge     = edge_no + lat;
            comp_cmd      = r.cmd;
            next_pop_edge = edge_no + lat + 2;
        end
        if (c == 2'b01 || c == 2'b10) begin
            r.cmd  = c;
            r.addr = a;
            if (mq.size() < DEPTH) begin
                mq.push_back(r);
                sb.push_back(r);
            end else begin
                m_drop++;
            end
        end
        if (c == 2'b11) m_ill++;
        if (clr) begin
            m_rd = '0; m_wr = '0; m_drop = '0; m_ill = '0;
        end
        exp_busy = (edge_no <= next_pop_edge - 2) || (mq.size() > 0);
        edge_no++;
    endtask

    // Present inputs for the next edge, then update the model just after it
    task automatic step(input logic [1:0] c, input logic [ADDR_W-1:0] a, input bit clr);
        ifc.cmd_in    = c;
        ifc.add_in    = a;
        ifc.stats_clr = clr;
        @(posedge clk);
        #1;
        model_edge(c, a, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 'x, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock
    task automatic do_reset();
        ifc.cmd_in    = 2'b00;
        ifc.add_in    = '0;
        ifc.stats_clr = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("rst_resp_cmd",   32'(ifc.resp_cmd),   32'd0);
        chk("rst_resp_addr",  32'(ifc.resp_addr),  32'd0);
        chk("rst_busy",       32'(ifc.busy),       32'd0);
        chk("rst_fifo_count", 32'(ifc.fifo_count), 32'd0);
        chk("rst_rd_count",   ifc.rd_count,        32'd0);
        chk("rst_wr_count",   ifc.wr_count,        32'd0);
        chk("rst_drop_count", ifc.drop_count,      32'd0);
        chk("rst_ill_count",  ifc.illegal_count,   32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every output with the model and pops the scoreboard on each completion
    always @(negedge clk) begin
        req_s r;
        if (started) begin
            chk("resp_valid", 32'(ifc.resp_valid), 32'(exp_resp));
            if (ifc.resp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_unexpected: got cmd %0h addr %0h, scoreboard empty", ifc.resp_cmd, ifc.resp_addr);
                end else begin
                    r = sb.pop_front();
                    chk("resp_cmd",  32'(ifc.resp_cmd),  32'(r.cmd));
                    chk("resp_addr", 32'(ifc.resp_addr), 32'(r.addr));
                end
            end else begin
                chk("resp_cmd_idle",  32'(ifc.resp_cmd),  32'd0);
                chk("resp_addr_idle", 32'(ifc.resp_addr), 32'd0);
            end
            chk("fifo_count",    32'(ifc.fifo_count), 32'(mq.size()));
            chk("busy",          32'(ifc.busy),       32'(exp_busy));
            chk("rd_count",      ifc.rd_count,        m_rd);
            chk("wr_count",      ifc.wr_count,        m_wr);
            chk("drop_count",    ifc.drop_count,      m_drop);
            chk("illegal_count", ifc.illegal_count,   m_ill);
        end
    end

    initial begin
        logic [1:0]        c;
        logic [ADDR_W-1:0] a;
        bit                clr;
        int                r;
        n_cmp   = 0;
        n_err   = 0;
        edge_no = 0;
        started = 1'b0;
        model_reset();
        rst_n         = 1'b1;
        ifc.cmd_in    = 2'b00;
        ifc.add_in    = '0;
        ifc.stats_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;

        // Single READ then single WRITE into an idle block
        step(2'b01, 26'h0ABCDEF, 1'b0);
        idle(8);
        step(2'b10, 26'h0000040, 1'b0);
        idle(6);

        // Burst of 12 READs: fills the queue and drops the overflow
        for (int i = 0; i < 12; i++) step(2'b01, ADDR_W'($urandom), 1'b0);
        idle(70);

        // Long mixed burst: queue stays full across IDLE pops, exercising push-on-popping-edge
        for (int i = 0; i < 40; i++) step(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, ADDR_W'($urandom), 1'b0);
        idle(80);

        // Illegal command with undefined address
        step(2'b11, 'x, 1'b0);
        idle(2);

        // Clear on the very edge a READ completes
        step(2'b01, 26'h1234567, 1'b0);
        idle(4);
        step(2'b00, 'x, 1'b1);
        idle(3);

        // Reset while BUSY with three requests queued; nothing must complete afterwards
        for (int i = 0; i < 4; i++) step(2'b01, ADDR_W'($urandom), 1'b0);
        do_reset();
        idle(12);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      c = 2'b00;
            else if (r < 65) c = 2'b01;
            else if (r < 90) c = 2'b10;
            else             c = 2'b11;
            a   = (c == 2'b01 || c == 2'b10) ? ADDR_W'($urandom) : 'x;
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step(c, a, clr);
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
